// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants and helpers for the 3x3 convolution partial-sum datapath.
//   PSUM_W  width of one signed PE product
//   NUM_PE  products per kernel beat (3x3)
//   TREE_W  width of the adder-tree result (cannot overflow for 9 lanes)
//   lane()         extracts signed product k from the packed psum bus
//   sat_to_width() clamps a wide signed value to a signed w-bit range
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int PSUM_W = 16;
    localparam int NUM_PE = 9;
    localparam int TREE_W = 20;
    localparam int GRP_W  = 18;
    localparam int BUS_W  = PSUM_W * NUM_PE;

    function automatic logic signed [PSUM_W-1:0] lane(input logic [BUS_W-1:0] bus,
                                                      input int k);
        return $signed(bus[PSUM_W*k +: PSUM_W]);
    endfunction

    // w must be in 2..63 so both limits are representable in 64 bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_adder_tree.sv
// -----------------------------------------------------------------------------
// psum_adder_tree
// Two-stage pipelined reduction of the nine signed products of one kernel beat.
// Stage 1 forms three 18-bit group sums, stage 2 the 20-bit total. The whole
// pipeline advances only while en is high; clr kills in-flight beats.
// Ports:
//   clk, nrst     clock, asynchronous active-low reset
//   clr           synchronous flush of the stage valids
//   en            pipeline advance enable (global stall when low)
//   in_valid      psum carries a beat (captured only when en is high)
//   psum[143:0]   nine 16-bit signed lanes, lane k = psum[16k+15:16k]
//   out_valid     out_sum carries a reduced beat
//   out_sum[19:0] signed sum of the nine lanes
// -----------------------------------------------------------------------------
module psum_adder_tree
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [BUS_W-1:0]         psum,
    output logic                     out_valid,
    output logic signed [TREE_W-1:0] out_sum
);

    logic signed [GRP_W-1:0]  grp_p1 [3];
    logic                     vld_p1;
    logic signed [TREE_W-1:0] sum_p2;
    logic                     vld_p2;

    // Control: valids are reset and flushed; data registers only follow en.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (clr) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
        end
    end

    // p0 -> p1: three group sums of three lanes each
    always_ff @(posedge clk) begin
        if (en) begin
            for (int g = 0; g < 3; g++) begin
                grp_p1[g] <= GRP_W'(lane(psum, 3*g))
                           + GRP_W'(lane(psum, 3*g + 1))
                           + GRP_W'(lane(psum, 3*g + 2));
            end
        end
    end

    // p1 -> p2: total of the three group sums
    always_ff @(posedge clk) begin
        if (en) begin
            sum_p2 <= TREE_W'(grp_p1[0]) + TREE_W'(grp_p1[1]) + TREE_W'(grp_p1[2]);
        end
    end

    assign out_valid = vld_p2;
    assign out_sum   = sum_p2;

endmodule

// File: rtl/conv3x3_psum_accum.sv
// -----------------------------------------------------------------------------
// conv3x3_psum_accum
// Accumulates adder-tree results of NUM_CH input channels into one output
// pixel and presents it on a valid/ready port. A pending pixel that is not
// accepted stalls the whole block (no internal FIFO).
// Build option: define PSUM_SAT_EN to saturate the accumulator on every add;
// otherwise the accumulator wraps modulo 2^ACC_W.
// Parameters: NUM_CH (>=1) channels per pixel, ACC_W (>=20, <=63) output width.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   clr                  synchronous flush of pipeline, counter and accumulator
//   psum_valid/ready     input beat handshake, psum_ready = !(out_valid && !out_ready)
//   psum[143:0]          nine 16-bit signed products
//   out_valid/ready      output pixel handshake
//   out_data[ACC_W-1:0]  signed accumulated pixel value
//   ch_cnt               channels already folded into the accumulator
// -----------------------------------------------------------------------------
module conv3x3_psum_accum
    import conv_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      clr,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic [BUS_W-1:0]          psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic [$clog2(NUM_CH):0]   ch_cnt
);

    localparam int CNT_W = $clog2(NUM_CH) + 1;

    logic                     en;
    logic                     tree_vld;
    logic signed [TREE_W-1:0] tree_sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     last_ch;

    // A pending pixel nobody takes freezes every stage, including intake.
    assign en         = !(out_valid && !out_ready);
    assign psum_ready = en;

    psum_adder_tree u_tree (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (clr),
        .en        (en),
        .in_valid  (psum_valid),
        .psum      (psum),
        .out_valid (tree_vld),
        .out_sum   (tree_sum)
    );

`ifdef PSUM_SAT_EN
    logic signed [63:0] wide_sum;
    logic signed [63:0] sat_sum;

    always_comb begin
        wide_sum = 64'(acc) + 64'(tree_sum);
        sat_sum  = sat_to_width(wide_sum, ACC_W);
        acc_sum  = sat_sum[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_sum = acc + ACC_W'(tree_sum);
    end
`endif

    assign last_ch = (ch_cnt == CNT_W'(NUM_CH - 1));

    // p2 -> p3: channel accumulation and output register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc       <= '0;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            acc       <= '0;
            ch_cnt    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A completing pixel overrides the clear above (back-to-back reload).
            if (tree_vld && en) begin
                if (last_ch) begin
                    out_data  <= acc_sum;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ch_cnt    <= '0;
                end else begin
                    acc    <= acc_sum;
                    ch_cnt <= ch_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
